// File: rtl/cond_pkg.sv
// Package for the conditional-execution unit.
// Holds the condition-code enum, the flag register layout and the
// flag write-group bit indices shared by cond_eval and cond_exec_unit.
package cond_pkg;

    localparam int FLAG_W = 4;

    // Bit positions inside flag_write_i
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Architectural flag register, ordered {C,N,V,Z} from MSB to LSB
    typedef struct packed {
        logic c;
        logic n;
        logic v;
        logic z;
    } flags_t;

endpackage

// File: rtl/cond_exec_unit_eval.sv
// cond_eval: combinational ARM condition-code evaluator.
// Ports:
//   cond      - condition field (cond_e)
//   flags     - flags of the instruction's context (flags_t)
//   cond_true - condition holds for these flags; 1111 never holds
//   is_undef  - condition field is the reserved 1111 encoding
module cond_eval
    import cond_pkg::*;
(
    input  cond_e  cond,
    input  flags_t flags,
    output logic   cond_true,
    output logic   is_undef
);

    logic ge;
    logic hi;
    logic gt;

    assign ge = (flags.n == flags.v);
    assign hi = flags.c & ~flags.z;
    assign gt = ~flags.z & ge;

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            COND_EQ: cond_true = flags.z;
            COND_NE: cond_true = ~flags.z;
            COND_CS: cond_true = flags.c;
            COND_CC: cond_true = ~flags.c;
            COND_MI: cond_true = flags.n;
            COND_PL: cond_true = ~flags.n;
            COND_VS: cond_true = flags.v;
            COND_VC: cond_true = ~flags.v;
            COND_HI: cond_true = hi;
            COND_LS: cond_true = ~hi;
            COND_GE: cond_true = ge;
            COND_LT: cond_true = ~ge;
            COND_GT: cond_true = gt;
            COND_LE: cond_true = ~gt;
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    assign is_undef = (cond == COND_NV);

endmodule

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: multi-context conditional-execution stage.
// Keeps one {C,N,V,Z} flag register per context, evaluates the incoming
// instruction's condition against its context's registered flags, gates
// the write/branch enables and registers them into the next stage.
//
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   valid_i, ctx_i, cond_i     - instruction presence, context, condition
//   alu_flags_i, flag_write_i  - new flags and per-group write mask
//   reg_write_i, mem_write_i, pc_src_i - raw enables
//   stall_i, flush_i           - hold / kill the output stage
//   load_i, load_ctx_i, load_flags_i - flag restore port (ignores stall)
//   rd_ctx_i, rd_flags_o       - combinational flag read (0 if out of range)
//   valid_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o - output stage
//   undef_o                    - present only with COND_UNDEF_TRAP_EN
//
// Configuration macro: COND_UNDEF_TRAP_EN adds the undef_o trap output.
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter int NCTX  = 2,
    parameter int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [CTX_W-1:0]  ctx_i,
    input  logic [3:0]        cond_i,
    input  logic [FLAG_W-1:0] alu_flags_i,
    input  logic [1:0]        flag_write_i,
    input  logic              reg_write_i,
    input  logic              mem_write_i,
    input  logic              pc_src_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [CTX_W-1:0]  load_ctx_i,
    input  logic [FLAG_W-1:0] load_flags_i,
    input  logic [CTX_W-1:0]  rd_ctx_i,
    output logic [FLAG_W-1:0] rd_flags_o,
    output logic              valid_o,
    output logic              cond_ex_o,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              pc_src_o
`ifdef COND_UNDEF_TRAP_EN
    ,
    output logic              undef_o
`endif
);

    flags_t flags_q [NCTX];

    flags_t ev_flags;
    flags_t rd_flags;
    flags_t alu_flags;
    flags_t ld_flags;
    logic   ctx_ok;
    logic   cond_true;
    logic   is_undef;
    logic   pass;
    logic   upd;

    assign alu_flags = flags_t'(alu_flags_i);
    assign ld_flags  = flags_t'(load_flags_i);

    // Context decode for the instruction and read ports. Matching only
    // against real context indices makes out-of-range indices read as 0
    // and keeps ctx_ok low for them.
    always_comb begin
        ev_flags = '0;
        rd_flags = '0;
        ctx_ok   = 1'b0;
        for (int k = 0; k < NCTX; k++) begin
            if (ctx_i == CTX_W'(k)) begin
                ev_flags = flags_q[k];
                ctx_ok   = 1'b1;
            end
            if (rd_ctx_i == CTX_W'(k)) begin
                rd_flags = flags_q[k];
            end
        end
    end

    assign rd_flags_o = rd_flags;

    cond_eval u_eval (
        .cond      (cond_e'(cond_i)),
        .flags     (ev_flags),
        .cond_true (cond_true),
        .is_undef  (is_undef)
    );

    assign pass = valid_i & cond_true & ctx_ok;
    assign upd  = pass & ~stall_i & ~flush_i;

    // Flag array. Restore takes priority over the instruction write on
    // all four bits of the same context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCTX; k++) begin
                flags_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCTX; k++) begin
                if (load_i && (load_ctx_i == CTX_W'(k))) begin
                    flags_q[k] <= ld_flags;
                end else if (upd && (ctx_i == CTX_W'(k))) begin
                    if (flag_write_i[FW_NZ]) begin
                        flags_q[k].n <= alu_flags.n;
                        flags_q[k].z <= alu_flags.z;
                    end
                    if (flag_write_i[FW_CV]) begin
                        flags_q[k].c <= alu_flags.c;
                        flags_q[k].v <= alu_flags.v;
                    end
                end
            end
        end
    end

    // Output stage: flush beats stall, stall holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o     <= 1'b0;
            cond_ex_o   <= 1'b0;
            reg_write_o <= 1'b0;
            mem_write_o <= 1'b0;
            pc_src_o    <= 1'b0;
        end else if (flush_i) begin
            valid_o     <= 1'b0;
            cond_ex_o   <= 1'b0;
            reg_write_o <= 1'b0;
            mem_write_o <= 1'b0;
            pc_src_o    <= 1'b0;
        end else if (!stall_i) begin
            valid_o     <= valid_i;
            cond_ex_o   <= pass;
            reg_write_o <= reg_write_i & pass;
            mem_write_o <= mem_write_i & pass;
            pc_src_o    <= pc_src_i & pass;
        end
    end

`ifdef COND_UNDEF_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            undef_o <= 1'b0;
        end else if (flush_i) begin
            undef_o <= 1'b0;
        end else if (!stall_i) begin
            undef_o <= valid_i & is_undef;
        end
    end
`else
    // The reserved encoding already fails in cond_eval; nothing to trap.
    logic unused_undef;
    assign unused_undef = is_undef;
`endif

endmodule

// File: tb/tb_cond_exec_unit.sv
module tb_cond_exec_unit;

    localparam int NCTX  = 3;
    localparam int CTX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_i;
    logic [CTX_W-1:0] ctx_i;
    logic [3:0]       cond_i;
    logic [3:0]       alu_flags_i;
    logic [1:0]       flag_write_i;
    logic             reg_write_i, mem_write_i, pc_src_i;
    logic             stall_i, flush_i, load_i;
    logic [CTX_W-1:0] load_ctx_i;
    logic [3:0]       load_flags_i;
    logic [CTX_W-1:0] rd_ctx_i;
    logic [3:0]       rd_flags_o;
    logic             valid_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o;
`ifdef COND_UNDEF_TRAP_EN
    logic             undef_o;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] o;   // {valid, cond_ex, reg_write, mem_write, pc_src}
        logic       ud;
        string      tag;
    } exp_t;

    exp_t sb[$];

    cond_exec_unit #(.NCTX(NCTX), .CTX_W(CTX_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ctx_i        (ctx_i),
        .cond_i       (cond_i),
        .alu_flags_i  (alu_flags_i),
        .flag_write_i (flag_write_i),
        .reg_write_i  (reg_write_i),
        .mem_write_i  (mem_write_i),
        .pc_src_i     (pc_src_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .load_i       (load_i),
        .load_ctx_i   (load_ctx_i),
        .load_flags_i (load_flags_i),
        .rd_ctx_i     (rd_ctx_i),
        .rd_flags_o   (rd_flags_o),
        .valid_o      (valid_o),
        .cond_ex_o    (cond_ex_o),
        .reg_write_o  (reg_write_o),
        .mem_write_o  (mem_write_o),
        .pc_src_o     (pc_src_o)
`ifdef COND_UNDEF_TRAP_EN
        ,
        .undef_o      (undef_o)
`endif
    );

    always #5 clk = ~clk;

    // Independent reference: pairs of codes share a base test, odd codes invert.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic fc, fn, fv, fz, b;
        {fc, fn, fv, fz} = f;
        case (c[3:1])
            3'd0: b = fz;
            3'd1: b = fc;
            3'd2: b = fn;
            3'd3: b = fv;
            3'd4: b = fc && !fz;
            3'd5: b = (fn == fv);
            3'd6: b = !fz && (fn == fv);
            default: return (c == 4'b1110);
        endcase
        return c[0] ? !b : b;
    endfunction

    task automatic clr();
        valid_i = 0; ctx_i = '0; cond_i = '0; alu_flags_i = '0; flag_write_i = '0;
        reg_write_i = 0; mem_write_i = 0; pc_src_i = 0;
        stall_i = 0; flush_i = 0; load_i = 0; load_ctx_i = '0; load_flags_i = '0;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] eo, input logic eu);
        logic [4:0] obs;
        obs = {valid_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o};
        total++;
        assert (obs === eo) else begin
            bad++;
            $error("FAIL %s outs got=%b want=%b", tag, obs, eo);
        end
`ifdef COND_UNDEF_TRAP_EN
        total++;
        assert (undef_o === eu) else begin
            bad++;
            $error("FAIL %s undef got=%b want=%b", tag, undef_o, eu);
        end
`else
        if (eu) begin end
`endif
    endtask

    // Push expectation for the currently driven inputs, clock, then pop/compare.
    task automatic tick(input string tag, input logic [4:0] eo, input logic eu);
        exp_t e, p;
        e.o = eo; e.ud = eu; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        chk_out(p.tag, p.o, p.ud);
    endtask

    task automatic chk_rd(input string tag, input logic [CTX_W-1:0] c, input logic [3:0] e);
        rd_ctx_i = c;
        #1;
        total++;
        assert (rd_flags_o === e) else begin
            bad++;
            $error("FAIL %s rd_flags[%0d] got=%b want=%b", tag, c, rd_flags_o, e);
        end
    endtask

    initial begin
        logic [3:0] fset [4];
        logic       p;
        fset[0] = 4'b1000; fset[1] = 4'b0110; fset[2] = 4'b0101; fset[3] = 4'b0010;

        clr();
        rd_ctx_i = '0;
        rst_n = 0;
        #3;
        chk_out("reset", 5'b00000, 1'b0);
        chk_rd("reset", 2'd0, 4'b0000);
        #3 rst_n = 1;

        // EQ with zero flags fails
        valid_i = 1; cond_i = 4'b0000; reg_write_i = 1;
        tick("eq_zero", 5'b10000, 1'b0);
        chk_rd("eq_zero", 2'd0, 4'b0000);

        // restore ctx1 = N
        clr(); load_i = 1; load_ctx_i = 2'd1; load_flags_i = 4'b0100;
        tick("load1", 5'b00000, 1'b0);
        chk_rd("load1", 2'd1, 4'b0100);

        clr(); valid_i = 1; ctx_i = 2'd1; cond_i = 4'b0100; reg_write_i = 1;
        tick("mi", 5'b11100, 1'b0);
        clr(); valid_i = 1; ctx_i = 2'd1; cond_i = 4'b1010; reg_write_i = 1;
        tick("ge", 5'b10000, 1'b0);

        // NZ-only write, then dependent EQ with no bubble
        clr(); valid_i = 1; cond_i = 4'b1110; flag_write_i = 2'b10; alu_flags_i = 4'b1111; reg_write_i = 1;
        tick("alu_nz", 5'b11100, 1'b0);
        chk_rd("alu_nz", 2'd0, 4'b0101);
        clr(); valid_i = 1; cond_i = 4'b0000; reg_write_i = 1; pc_src_i = 1;
        tick("b2b_eq", 5'b11101, 1'b0);

        // stall holds outputs and blocks flag write
        clr(); valid_i = 1; cond_i = 4'b1110; flag_write_i = 2'b11; mem_write_i = 1; stall_i = 1;
        tick("stall", 5'b11101, 1'b0);
        chk_rd("stall", 2'd0, 4'b0101);

        // flush kills output and blocks flag write
        clr(); valid_i = 1; cond_i = 4'b1110; flag_write_i = 2'b11; flush_i = 1; reg_write_i = 1;
        tick("flush", 5'b00000, 1'b0);
        chk_rd("flush", 2'd0, 4'b0101);

        // restore beats same-cycle instruction write
        clr(); valid_i = 1; cond_i = 4'b1110; flag_write_i = 2'b11; alu_flags_i = 4'b1101; reg_write_i = 1;
        load_i = 1; load_flags_i = 4'b0010;
        tick("ld_vs_wr", 5'b11100, 1'b0);
        chk_rd("ld_vs_wr", 2'd0, 4'b0010);

        // reserved condition
        clr(); valid_i = 1; cond_i = 4'b1111; mem_write_i = 1;
        tick("nv", 5'b10000, 1'b1);

        // out-of-range context
        clr(); valid_i = 1; ctx_i = 2'd3; cond_i = 4'b1110; pc_src_i = 1; flag_write_i = 2'b11; alu_flags_i = 4'b1111;
        tick("ctx_oor", 5'b10000, 1'b0);
        chk_rd("ctx_oor", 2'd0, 4'b0010);
        chk_rd("ctx_oor", 2'd1, 4'b0100);
        chk_rd("ctx_oor", 2'd2, 4'b0000);
        chk_rd("ctx_oor", 2'd3, 4'b0000);

        // CV-only write
        clr(); valid_i = 1; ctx_i = 2'd2; cond_i = 4'b1110; flag_write_i = 2'b01; alu_flags_i = 4'b1111;
        tick("alu_cv", 5'b11000, 1'b0);
        chk_rd("alu_cv", 2'd2, 4'b1010);

        // condition table sweep on ctx2
        for (int s = 0; s < 4; s++) begin
            clr(); load_i = 1; load_ctx_i = 2'd2; load_flags_i = fset[s];
            tick("sweep_ld", 5'b00000, 1'b0);
            for (int c = 0; c < 16; c++) begin
                clr(); valid_i = 1; ctx_i = 2'd2; cond_i = 4'(c);
                reg_write_i = 1; mem_write_i = cond_i[0]; pc_src_i = cond_i[1];
                p = ref_cond(cond_i, fset[s]);
                tick($sformatf("sweep_f%b_c%b", fset[s], cond_i),
                     {1'b1, p, p, p & cond_i[0], p & cond_i[1]}, cond_i == 4'b1111);
            end
        end

        // async reset in the middle of a stall
        clr(); valid_i = 1; cond_i = 4'b1110; reg_write_i = 1;
        tick("pre_rst", 5'b11100, 1'b0);
        clr(); stall_i = 1;
        #2 rst_n = 0;
        #1;
        chk_out("rst_mid", 5'b00000, 1'b0);
        chk_rd("rst_mid", 2'd1, 4'b0000);
        #1 rst_n = 1;
        clr();
        tick("post_rst", 5'b00000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cond_exec_unit.md
# cond_exec_unit

Multi-context, pipelined conditional-execution unit for the CPU control path. It holds one architectural flag register {C,N,V,Z} per hardware context and evaluates each instruction's 4-bit ARM condition field against its context's flags. It gates the instruction's write and branch enables, updates flags with per-group write masks, and registers the result into the next pipeline stage with stall and flush support. It also provides a save/restore port for context switching.

## Interface
- NCTX, default 2: number of flag contexts, at least 1.
- CTX_W, default $clog2(NCTX) with a minimum of 1: context index width.

- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- valid_i, input, 1: instruction present this cycle.
- ctx_i, input, CTX_W: context of the instruction.
- cond_i, input, 4: condition field.
- alu_flags_i, input, 4: new flags from the ALU, ordered {C,N,V,Z}.
- flag_write_i, input, 2: bit1 updates N,Z; bit0 updates C,V.
- reg_write_i, input, 1: raw register-write enable.
- mem_write_i, input, 1: raw memory-write enable.
- pc_src_i, input, 1: raw branch enable.
- stall_i, input, 1: hold the output stage and block updates.
- flush_i, input, 1: kill the output stage.
- load_i, input, 1: flag restore strobe.
- load_ctx_i, input, CTX_W: context to restore.
- load_flags_i, input, 4: restore value, ordered {C,N,V,Z}.
- rd_ctx_i, input, CTX_W: flag read address.
- rd_flags_o, output, 4: combinational read of flags[rd_ctx_i].
- valid_o, output, 1: output stage holds an instruction.
- cond_ex_o, output, 1: the registered condition passed.
- reg_write_o, output, 1: gated register-write enable.
- mem_write_o, output, 1: gated memory-write enable.
- pc_src_o, output, 1: gated branch enable.
- undef_o, output, 1: trap flag; exists only when the macro is defined.

## Operation
- Flag decode: from the stored flags, GE = (N == V).
- Condition table:
  - 0000 EQ = Z; 0001 NE = ~Z.
  - 0010 CS = C; 0011 CC = ~C.
  - 0100 MI = N; 0101 PL = ~N.
  - 0110 VS = V; 0111 VC = ~V.
  - 1000 HI = C&~Z; 1001 LS = ~(C&~Z).
  - 1010 GE; 1011 LT = ~GE.
  - 1100 GT = ~Z&GE; 1101 LE = ~(~Z&GE).
  - 1110 AL = 1.
  - 1111: see Configuration.
- Evaluation always uses the registered flags of ctx_i. It never sees alu_flags_i of the same cycle.
- pass = valid_i & cond_true & (ctx_i < NCTX). An out-of-range context never passes and never writes flags.
- Flag update at the clock edge, when pass & ~stall_i & ~flush_i:
  - flag_write_i[1] loads N and Z of flags[ctx_i] from alu_flags_i.
  - flag_write_i[0] loads C and V of flags[ctx_i] from alu_flags_i.
- Restore: when load_i is high, flags[load_ctx_i] is loaded with load_flags_i. load_i ignores stall_i.
- Restore and instruction write to the same context in the same cycle: the restore wins on all four bits.
- Output stage update rules, in priority order:
  - flush_i high: clear all output bits.
  - stall_i high: hold all outputs.
  - Otherwise: valid_o <= valid_i, cond_ex_o <= pass, and each of reg_write_o, mem_write_o, pc_src_o <= its raw enable & pass.
- rd_flags_o returns the pre-edge value. An out-of-range rd_ctx_i returns 0.

## Timing
- Reset, asynchronous: all flag registers are 0, and every output-stage bit (valid_o, cond_ex_o, the gated enables, undef_o) is 0.
- Reset mid-stall clears state immediately. The first post-reset cycle behaves as empty.
- Latency is one cycle from inputs to the gated outputs.
- Back-to-back instructions in the same context: the second sees the flags written by the first, with no bubble. No bypass exists within a single cycle.
- flush_i together with valid_i: the instruction is dropped and does not update flags.
- stall_i together with valid_i: the instruction does not update flags. Upstream must re-present it.

## Configuration
- COND_UNDEF_TRAP_EN defined:
  - cond 1111 gives pass=0.
  - When the output stage loads the instruction with valid_i=1, undef_o is set to 1. undef_o is held by stall_i and cleared by flush_i, like the other output bits.
- COND_UNDEF_TRAP_EN undefined:
  - cond 1111 evaluates as never, with pass=0.
  - There is no undef_o port.
  - No X is ever produced.

## Structure
- Package cond_pkg holds:
  - cond_e, the enum of the 16 condition codes.
  - flags_t, a packed struct {C,N,V,Z}.
  - FLAG_W=4.
  - Flag write-group bit indices FW_NZ=1 and FW_CV=0.
- Sub-module cond_eval: combinational; inputs cond_e and flags_t; outputs cond_true and is_undef. It is instantiated once for the instruction path.
- The top level holds the flag array, the update and restore logic, and the output register.

## Test plan
- Reset, then cond=0000 with flags 0 in ctx0 → cond_ex_o=0 and reg_write_o=0 one cycle later; rd_flags_o=0.
- load ctx1 with 4'b0100 (N=1) → next cycle cond=0100 with reg_write_i=1 → reg_write_o=1; cond=1010 (GE, since N≠V) → cond_ex_o=0.
- ALU op in ctx0 with flag_write=2'b10 and alu_flags=4'b1111 → only N,Z change, so rd_flags_o=4'b0101. The following cond=0000 instruction passes with no bubble.
- stall_i=1 with a valid passing instruction → outputs hold their previous values and flags are unchanged. flush_i=1 → valid_o=0 and no flag write.
- Same-cycle load_i to ctx0 with 4'b0010 and an instruction write to ctx0 with alu_flags 4'b1101 → flags[ctx0]=4'b0010.
- cond=1111 with mem_write_i=1 → mem_write_o=0; with COND_UNDEF_TRAP_EN defined, undef_o=1 after one cycle. With NCTX=3 and ctx_i=3, pc_src_o stays 0 and no flags change.
